// File: rtl/key_pio_pkg.sv
// Register map and key polarity shared by the debounced pushbutton PIO.
package key_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE    = 2'd3;

  // DE2 keys pull low when pressed, so an idle pin reads 1.
  localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_debounce_bit.sv
// One pushbutton: two-flop synchronizer, stability counter, accepted level
// and a single-cycle pulse on each accepted press.
module key_debounce_bit
  import key_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_count;
  logic             r_level;
  logic             r_pulse;
  logic             w_pressed;

  assign w_pressed = (r_stable != KEY_RELEASED);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= KEY_RELEASED;
      r_sync2 <= KEY_RELEASED;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Any sample that agrees with the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stable <= KEY_RELEASED;
      r_count  <= '0;
    end else if (r_sync2 != r_stable) begin
      if (r_count == LAST_COUNT) begin
        r_stable <= r_sync2;
        r_count  <= '0;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end else begin
      r_count <= '0;
    end
  end

  // Pulse is registered alongside the level so both rise on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_level <= w_pressed;
      r_pulse <= w_pressed && !r_level;
    end
  end

  assign o_level       = r_level;
  assign o_press_pulse = r_pulse;

endmodule

// File: rtl/key_debounce_pio.sv
// Debounced pushbutton bank behind a PIO-compatible Avalon-MM slave with
// data, interrupt mask and write-1-to-clear edge capture registers.
module key_debounce_pio
  import key_pio_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n_in,
  input  logic [1:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic                irq,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press_pulse
);

  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] w_pulse;
  logic [NUM_KEYS-1:0] w_clear;
  logic [NUM_KEYS-1:0] r_irqmask;
  logic [NUM_KEYS-1:0] r_edgecap;
  logic [31:0]         r_readdata;
  logic [31:0]         w_rdata;
  logic                w_wr_mask;
  logic                w_unused_wdata;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_key_n      (key_n_in[i]),
      .o_level      (w_level[i]),
      .o_press_pulse(w_pulse[i])
    );
  end

  assign w_wr_mask      = avs_write && (avs_address == ADDR_IRQMASK);
  assign w_clear        = (avs_write && (avs_address == ADDR_EDGE)) ?
                          avs_writedata[NUM_KEYS-1:0] : '0;
  assign w_unused_wdata = ^avs_writedata;

  always_comb begin
    w_rdata = '0;
    case (avs_address)
      ADDR_DATA:    w_rdata[NUM_KEYS-1:0] = w_level;
      ADDR_RSVD:    w_rdata = '0;
      ADDR_IRQMASK: w_rdata[NUM_KEYS-1:0] = r_irqmask;
      ADDR_EDGE:    w_rdata[NUM_KEYS-1:0] = r_edgecap;
      default:      w_rdata = '0;
    endcase
  end

  // A new press is ORed in after the clear so it is never lost to a W1C.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_irqmask  <= '0;
      r_edgecap  <= '0;
      r_readdata <= '0;
    end else begin
      if (w_wr_mask) begin
        r_irqmask <= avs_writedata[NUM_KEYS-1:0];
      end
      r_edgecap <= (r_edgecap & ~w_clear) | w_pulse;
      if (avs_read) begin
        r_readdata <= w_rdata;
      end
    end
  end

  assign avs_readdata    = r_readdata;
  assign irq             = |(r_edgecap & r_irqmask);
  assign key_level       = w_level;
  assign key_press_pulse = w_pulse;

endmodule

// File: doc/key_debounce_pio.md
Name: key_debounce_pio

Overview:
- Conditions the raw active-low DE2 pushbuttons before they reach the Nios key PIO path.
- Per key: two-flop synchronizer, debounce counter, press-event detection.
- Exposes a PIO-compatible Avalon-MM slave: data, interrupt mask and edge-capture registers, plus an IRQ.
- Sits between the board KEY pins and the Nios system interconnect. Existing key-polling software keeps working unchanged.

Parameters:
- NUM_KEYS, 4: number of pushbutton inputs; 1..32.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a level is accepted (10 ms at 50 MHz); minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): debounce counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  synchronous active-low reset.
- key_n_in  in  NUM_KEYS  raw pushbuttons, asynchronous, 0 = pressed.
- avs_address  in  2  register word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered.
- irq  out  1  level interrupt, active-high.
- key_level  out  NUM_KEYS  debounced state, 1 = pressed.
- key_press_pulse  out  NUM_KEYS  one-cycle pulse per accepted press.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset_n is sampled on the rising clk edge, active-low and synchronous. No asynchronous reset anywhere.
- Reset values:
  - Synchronizer flops = 1 (released); stable = 1; counters = 0.
  - key_level = 0, key_press_pulse = 0, edgecapture = 0, irqmask = 0, avs_readdata = 0, irq = 0.
- Synchronizer: two flops per key on key_n_in; output sync[i].
- Debounce (per key):
  - If sync != stable and count == DEBOUNCE_CYCLES-1: stable <= sync, count <= 0.
  - Else if sync != stable: count <= count+1.
  - Else: count <= 0. Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
- Latency: a clean input transition appears on key_level exactly DEBOUNCE_CYCLES+2 clk edges after the edge that first samples it.
- key_level = ~stable. Releases are debounced identically.
- key_press_pulse[i]: high for exactly one cycle, the first cycle key_level[i] reads 1. Releases produce no pulse.
- Register map, 32-bit words, unused bits read 0:
  - 0 DATA: read-only, returns key_level; writes ignored.
  - 1 reserved: reads 0; writes ignored.
  - 2 IRQMASK: read/write, bits [NUM_KEYS-1:0].
  - 3 EDGECAPTURE: read / write-1-to-clear.
- Edge capture:
  - edgecapture[i] sets on key_press_pulse[i].
  - A write to address 3 clears each bit where writedata = 1.
  - Set and clear in the same cycle on the same bit: set wins (bit stays 1).
- Read timing:
  - Read latency is 1 cycle. avs_readdata updates on the edge after avs_read is sampled and holds between reads.
  - A read sees register state from before any same-cycle write.
  - Simultaneous avs_read and avs_write: both performed.
- irq = |(edgecapture & irqmask), driven from registered state with no extra latency. It stays asserted until software clears the bits or masks them.
- Reset mid-debounce: counters clear; stable returns to released. A key held through reset is re-accepted DEBOUNCE_CYCLES+2 cycles after release of reset and generates a press pulse.

Decomposition:
- Package key_pio_pkg holds:
  - localparams ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQMASK=2, ADDR_EDGE=3;
  - constant KEY_RELEASED=1'b1.
- One sub-module, key_debounce_bit: synchronizer, counter, stable flop and press pulse for a single key. It is instantiated NUM_KEYS times in a generate loop.
- The top holds the register file, the Avalon read/write decode and the irq.

Test Plan (DEBOUNCE_CYCLES=16, NUM_KEYS=4):
- Clean press: drive key_n_in[1] 1->0 and hold. key_level[1] rises exactly 18 cycles later; key_press_pulse[1] is high for 1 cycle; a read of address 3 returns 0x2.
- Bounce: toggle key_n_in[2] every 5 cycles for 60 cycles, then hold 0. key_level[2] stays 0 during bouncing, then rises 18 cycles after the final edge; exactly one pulse.
- Release: after the press from the first test, drive key_n_in[1] 0->1. key_level[1] falls 18 cycles later; no pulse; edgecapture is unchanged.
- IRQ/W1C:
  - Write IRQMASK=0x4, then press key 2: irq=1.
  - Press key 1 as well: EDGECAPTURE reads 0x6.
  - Write 0x4 to address 3: EDGECAPTURE=0x2, irq=0.
  - Write 0x0 to address 2: irq stays 0.
- Set/clear collision: W1C write of 0x8 to address 3 in the same cycle key_press_pulse[3]=1 -> EDGECAPTURE[3] reads 1.
- Reset mid-operation:
  - Assert reset_n=0 for 1 cycle while key 0 is held with the counter at 10. All outputs and registers return to 0.
  - With the key still held, key_level[0] rises 18 cycles after reset release, with one pulse.
